// File: rtl/hdmi_refresh_tick_if.sv
// hdmi_refresh_tick_if: control inputs and tick/status outputs of the HDMI refresh tick block
interface hdmi_refresh_tick_if #(
    parameter int DIV_WIDTH = 4,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 vsync;
    logic [DIV_WIDTH-1:0] frame_div;
    logic                 clear_missed;
    logic                 refresh_out;
    logic                 tick;
    logic [CNT_WIDTH-1:0] frame_count;
    logic                 missed;

    modport master (
        output enable, vsync, frame_div, clear_missed,
        input  refresh_out, tick, frame_count, missed
    );

    modport slave (
        input  enable, vsync, frame_div, clear_missed,
        output refresh_out, tick, frame_count, missed
    );
endinterface

// File: rtl/hdmi_refresh_tick.sv
// hdmi_refresh_tick: vsync-divided game tick with a held refresh level, frame counter and overrun flag
module hdmi_refresh_tick #(
    parameter int VSYNC_ACTIVE_HIGH = 1,
    parameter int DIV_WIDTH         = 4,
    parameter int HOLD_CYCLES       = 1024,
    parameter int CNT_WIDTH         = 16
) (
    input logic                clk,
    input logic                reset,
    hdmi_refresh_tick_if.slave bus
);
    localparam logic        VS_INV    = (VSYNC_ACTIVE_HIGH == 0);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state;
    logic                 vs_r, vs_r2;
    logic                 frame_edge, fire;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [15:0]          hold_cnt;
    logic [CNT_WIDTH-1:0] frame_count;
    logic                 refresh_out, tick, missed;

    assign frame_edge = vs_r & ~vs_r2;
    assign fire       = frame_edge & bus.enable & (div_cnt >= bus.frame_div);

    // normalise vsync polarity and delay it twice to find the start of the active pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_r  <= 1'b0;
            vs_r2 <= 1'b0;
        end else begin
            vs_r  <= bus.vsync ^ VS_INV;
            vs_r2 <= vs_r;
        end
    end

    // free-running frame counter and the enable-gated frame divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            div_cnt     <= '0;
        end else begin
            if (frame_edge) frame_count <= frame_count + 1'b1;
            if (!bus.enable) div_cnt <= '0;
            else if (frame_edge) div_cnt <= fire ? '0 : div_cnt + 1'b1;
        end
    end

    // hold FSM: registered refresh level, one-cycle tick and sticky overrun flag (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            refresh_out <= 1'b0;
            tick        <= 1'b0;
            missed      <= 1'b0;
        end else begin
            tick   <= fire;
            missed <= (fire && state == HOLD) ? 1'b1 : (bus.clear_missed ? 1'b0 : missed);
            if (!bus.enable) begin
                state       <= IDLE;
                refresh_out <= 1'b0;
            end else if (fire) begin
                state       <= HOLD;
                refresh_out <= 1'b1;
                hold_cnt    <= HOLD_LOAD;
            end else if (state == HOLD) begin
                if (hold_cnt == '0) begin
                    state       <= IDLE;
                    refresh_out <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.refresh_out = refresh_out;
    assign bus.tick        = tick;
    assign bus.frame_count = frame_count;
    assign bus.missed      = missed;
endmodule

// File: tb/tb_hdmi_refresh_tick.sv
// tb_hdmi_refresh_tick: directed table-driven and hand-sequenced checks of hdmi_refresh_tick
module tb_hdmi_refresh_tick;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hdmi_refresh_tick_if #(.DIV_WIDTH(4), .CNT_WIDTH(16)) ia();
    hdmi_refresh_tick_if #(.DIV_WIDTH(4), .CNT_WIDTH(16)) ib();
    hdmi_refresh_tick_if #(.DIV_WIDTH(4), .CNT_WIDTH(16)) ic();
    hdmi_refresh_tick_if #(.DIV_WIDTH(4), .CNT_WIDTH(8))  id();

    assign id.enable       = ia.enable;
    assign id.vsync        = ia.vsync;
    assign id.frame_div    = ia.frame_div;
    assign id.clear_missed = ia.clear_missed;

    hdmi_refresh_tick #(.VSYNC_ACTIVE_HIGH(1), .DIV_WIDTH(4), .HOLD_CYCLES(4),   .CNT_WIDTH(16)) ua (.clk(clk), .reset(reset), .bus(ia));
    hdmi_refresh_tick #(.VSYNC_ACTIVE_HIGH(1), .DIV_WIDTH(4), .HOLD_CYCLES(200), .CNT_WIDTH(16)) ub (.clk(clk), .reset(reset), .bus(ib));
    hdmi_refresh_tick #(.VSYNC_ACTIVE_HIGH(0), .DIV_WIDTH(4), .HOLD_CYCLES(4),   .CNT_WIDTH(16)) uc (.clk(clk), .reset(reset), .bus(ic));
    hdmi_refresh_tick #(.VSYNC_ACTIVE_HIGH(1), .DIV_WIDTH(4), .HOLD_CYCLES(1),   .CNT_WIDTH(8))  ud (.clk(clk), .reset(reset), .bus(id));

    int n_tick_a = 0, n_ref_a = 0, n_tick_d = 0, n_ref_d = 0, n_tick_b = 0, n_low_b = 0;

    // count tick pulses and level cycles on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (ia.tick) n_tick_a++;
        if (ia.refresh_out) n_ref_a++;
        if (id.tick) n_tick_d++;
        if (id.refresh_out) n_ref_d++;
        if (ib.tick) n_tick_b++;
        if (!ib.refresh_out) n_low_b++;
    end

    typedef struct {
        logic [3:0] div;
        int         pulses;
        int         gap;
        int         ticks;
        int         refs;
    } vec_t;

    vec_t vecs[6];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_a(input int hi, input int gap);
        ia.vsync = 1'b1;
        step(hi);
        ia.vsync = 1'b0;
        step(gap - hi);
    endtask

    task automatic pulse_b(input int gap);
        ib.vsync = 1'b1;
        step(5);
        ib.vsync = 1'b0;
        step(gap - 5);
    endtask

    initial begin
        int fc_exp;
        int t0, r0, td0, rd0, low0;
        vecs[0] = '{4'd0,  2, 100, 2, 8};
        vecs[1] = '{4'd2,  9, 20,  3, 12};
        vecs[2] = '{4'd7,  5, 20,  0, 0};
        vecs[3] = '{4'd1,  1, 20,  1, 4};
        vecs[4] = '{4'd1,  4, 20,  2, 8};
        vecs[5] = '{4'd15, 16, 12, 1, 4};
        ia.enable = 1'b0; ia.vsync = 1'b0; ia.frame_div = '0; ia.clear_missed = 1'b0;
        ib.enable = 1'b0; ib.vsync = 1'b0; ib.frame_div = '0; ib.clear_missed = 1'b0;
        ic.enable = 1'b0; ic.vsync = 1'b1; ic.frame_div = '0; ic.clear_missed = 1'b0;
        step(3);
        chk("rst_refresh", 32'(ia.refresh_out), 32'd0);
        chk("rst_tick", 32'(ia.tick), 32'd0);
        chk("rst_count", 32'(ia.frame_count), 32'd0);
        chk("rst_missed", 32'(ia.missed), 32'd0);
        chk("rst_refresh_b", 32'(ib.refresh_out), 32'd0);
        chk("rst_count_c", 32'(ic.frame_count), 32'd0);
        reset = 1'b0;
        step(2);
        ia.enable = 1'b1;
        step(1);
        ia.vsync = 1'b1;
        step(1);
        chk("lat_tick_early", 32'(ia.tick), 32'd0);
        step(1);
        chk("lat_tick", 32'(ia.tick), 32'd1);
        chk("lat_refresh", 32'(ia.refresh_out), 32'd1);
        chk("lat_count", 32'(ia.frame_count), 32'd1);
        step(1);
        chk("tick_width", 32'(ia.tick), 32'd0);
        chk("hold_mid", 32'(ia.refresh_out), 32'd1);
        step(2);
        chk("hold_last", 32'(ia.refresh_out), 32'd1);
        step(1);
        chk("hold_end", 32'(ia.refresh_out), 32'd0);
        ia.vsync = 1'b0;
        step(94);
        fc_exp = 1;
        for (int i = 0; i < 6; i++) begin
            ia.frame_div = vecs[i].div;
            t0 = n_tick_a; r0 = n_ref_a; td0 = n_tick_d; rd0 = n_ref_d;
            for (int p = 0; p < vecs[i].pulses; p++) pulse_a(5, vecs[i].gap);
            fc_exp += vecs[i].pulses;
            chk($sformatf("vec%0d_ticks", i), 32'(n_tick_a - t0), 32'(vecs[i].ticks));
            chk($sformatf("vec%0d_refresh_cycles", i), 32'(n_ref_a - r0), 32'(vecs[i].refs));
            chk($sformatf("vec%0d_ticks_h1", i), 32'(n_tick_d - td0), 32'(vecs[i].ticks));
            chk($sformatf("vec%0d_refresh_h1", i), 32'(n_ref_d - rd0), 32'(vecs[i].ticks));
            chk($sformatf("vec%0d_count", i), 32'(ia.frame_count), 32'(fc_exp[15:0]));
            chk($sformatf("vec%0d_count_h1", i), 32'(id.frame_count), 32'(fc_exp[7:0]));
            chk($sformatf("vec%0d_missed", i), 32'(ia.missed), 32'd0);
        end
        ib.enable = 1'b1;
        ib.vsync = 1'b1;
        step(2);
        chk("ovr_tick1", 32'(ib.tick), 32'd1);
        chk("ovr_refresh1", 32'(ib.refresh_out), 32'd1);
        chk("ovr_missed1", 32'(ib.missed), 32'd0);
        low0 = n_low_b;
        step(3);
        ib.vsync = 1'b0;
        step(45);
        ib.vsync = 1'b1;
        step(2);
        chk("ovr_tick2", 32'(ib.tick), 32'd1);
        chk("ovr_missed2", 32'(ib.missed), 32'd1);
        step(3);
        ib.vsync = 1'b0;
        step(45);
        chk("ovr_continuous", 32'(n_low_b - low0), 32'd0);
        chk("ovr_count", 32'(ib.frame_count), 32'd2);
        ib.clear_missed = 1'b1;
        step(1);
        ib.clear_missed = 1'b0;
        chk("clear_missed", 32'(ib.missed), 32'd0);
        ib.vsync = 1'b1;
        step(1);
        ib.clear_missed = 1'b1;
        step(1);
        ib.clear_missed = 1'b0;
        chk("set_beats_clear", 32'(ib.missed), 32'd1);
        chk("set_beats_clear_tick", 32'(ib.tick), 32'd1);
        step(3);
        ib.vsync = 1'b0;
        step(5);
        ib.clear_missed = 1'b1;
        step(1);
        ib.clear_missed = 1'b0;
        ib.enable = 1'b0;
        step(1);
        chk("dis_refresh", 32'(ib.refresh_out), 32'd0);
        t0 = n_tick_b;
        pulse_b(20);
        pulse_b(20);
        chk("dis_no_tick", 32'(n_tick_b - t0), 32'd0);
        chk("dis_count", 32'(ib.frame_count), 32'd5);
        chk("dis_missed", 32'(ib.missed), 32'd0);
        ib.enable = 1'b1;
        step(1);
        ib.vsync = 1'b1;
        step(2);
        chk("reen_tick", 32'(ib.tick), 32'd1);
        chk("reen_refresh", 32'(ib.refresh_out), 32'd1);
        chk("reen_count", 32'(ib.frame_count), 32'd6);
        ib.vsync = 1'b0;
        step(3);
        ic.enable = 1'b1;
        step(1);
        ic.vsync = 1'b0;
        step(2);
        chk("low_fall_tick", 32'(ic.tick), 32'd1);
        chk("low_fall_count", 32'(ic.frame_count), 32'd1);
        step(3);
        ic.vsync = 1'b1;
        step(2);
        chk("low_rise_tick", 32'(ic.tick), 32'd0);
        chk("low_rise_count", 32'(ic.frame_count), 32'd1);
        step(3);
        chk("low_hold_end", 32'(ic.refresh_out), 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        ia.enable = 1'b0;
        ia.frame_div = '0;
        step(1);
        repeat (254) pulse_a(1, 2);
        step(2);
        chk("fast_count", 32'(ia.frame_count), 32'h00FE);
        ia.enable = 1'b1;
        ia.vsync = 1'b1;
        step(2);
        chk("pre_rst_count", 32'(ia.frame_count), 32'h00FF);
        chk("pre_rst_refresh", 32'(ia.refresh_out), 32'd1);
        chk("pre_rst_count_h1", 32'(id.frame_count), 32'h00FF);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_refresh", 32'(ia.refresh_out), 32'd0);
        chk("async_rst_tick", 32'(ia.tick), 32'd0);
        chk("async_rst_count", 32'(ia.frame_count), 32'd0);
        chk("async_rst_missed", 32'(ia.missed), 32'd0);
        ia.vsync = 1'b0;
        ia.enable = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        repeat (255) pulse_a(1, 2);
        step(2);
        chk("wrap_pre", 32'(id.frame_count), 32'h00FF);
        pulse_a(1, 2);
        step(2);
        chk("wrap_zero", 32'(id.frame_count), 32'h0000);
        chk("wrap_wide", 32'(ia.frame_count), 32'h0100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
